// File: rtl/fl_sched.sv
// fl_sched: round-robin scheduler sharing one fully connected layer MAC path
// among NUM CNN unit result registers. Grants one requester at a time, starts
// the FL, waits for completion (or timeout), acknowledges the unit and counts
// completed blocks of NUM operands.
module fl_sched #(
    parameter int NUM     = 8,
    parameter int IDX_W   = 3,
    parameter int BLK_W   = 7,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             restart,
    input  logic [BLK_W-1:0] total_blocks,
    input  logic [NUM-1:0]   req,
    input  logic             fl_done,
    output logic [IDX_W-1:0] sel,
    output logic             fl_start,
    output logic [NUM-1:0]   ack,
    output logic [BLK_W-1:0] blk_count,
    output logic             busy,
    output logic             all_done,
    output logic             err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StGrant = 3'd1;
    localparam logic [2:0] StWait  = 3'd2;
    localparam logic [2:0] StAck   = 3'd3;
    localparam logic [2:0] StDone  = 3'd4;

    localparam logic [IDX_W:0]   NumWide = (IDX_W + 1)'(NUM);
    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM - 1);
    // Counter value in the last WAIT cycle before a forced completion.
    localparam logic [CNT_W-1:0] ToLast  = CNT_W'(TIMEOUT - 1);

    logic [2:0]       state_q, state_d;
    logic [IDX_W-1:0] sel_q, sel_d;
    logic             fl_start_q, fl_start_d;
    logic [NUM-1:0]   ack_q, ack_d;
    logic [BLK_W-1:0] blk_q, blk_d;
    logic             busy_q, busy_d;
    logic             all_done_q, all_done_d;
    logic             err_q, err_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] served_q, served_d;
    logic [CNT_W-1:0] wcnt_q, wcnt_d;

    logic [2*NUM-1:0] req_dbl;
    logic [NUM-1:0]   req_rot;
    logic             pick_valid;
    logic [IDX_W-1:0] pick_off;
    logic [IDX_W:0]   pick_sum;
    logic [IDX_W:0]   pick_wrap;
    logic [IDX_W-1:0] pick_idx;
    logic [IDX_W-1:0] ptr_inc;
    logic [NUM-1:0]   ack_sel;
    logic [BLK_W-1:0] blk_inc;

    // Rotate requests so bit 0 corresponds to the round-robin pointer.
    assign req_dbl   = {req, req} >> ptr_q;
    assign req_rot   = req_dbl[NUM-1:0];
    assign pick_sum  = {1'b0, ptr_q} + {1'b0, pick_off};
    assign pick_wrap = pick_sum - NumWide;
    assign pick_idx  = (pick_sum >= NumWide) ? pick_wrap[IDX_W-1:0] : pick_sum[IDX_W-1:0];
    assign ptr_inc   = (sel_q == LastIdx) ? '0 : sel_q + IDX_W'(1);
    assign ack_sel   = NUM'(1) << sel_q;
    assign blk_inc   = blk_q + BLK_W'(1);

    // Lowest set bit of the rotated request vector is the next grant offset.
    always_comb begin
        pick_valid = |req_rot;
        pick_off   = '0;
        for (int k = NUM - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                pick_off = IDX_W'(k);
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        fl_start_d = 1'b0;
        ack_d      = '0;
        blk_d      = blk_q;
        all_done_d = all_done_q;
        err_d      = err_q;
        ptr_d      = ptr_q;
        served_d   = served_q;
        wcnt_d     = wcnt_q;

        if (restart) begin
            // Abort wins over any fl_done or timeout in the same cycle.
            state_d    = StIdle;
            blk_d      = '0;
            all_done_d = 1'b0;
            err_d      = 1'b0;
            ptr_d      = '0;
            served_d   = '0;
            wcnt_d     = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (enable && pick_valid && !all_done_q) begin
                        sel_d      = pick_idx;
                        fl_start_d = 1'b1;
                        state_d    = StGrant;
                    end
                end
                StGrant: begin
                    wcnt_d  = '0;
                    state_d = StWait;
                end
                StWait: begin
                    if (fl_done) begin
                        ack_d   = ack_sel;
                        state_d = StAck;
                    end else if (wcnt_q == ToLast) begin
                        err_d   = 1'b1;
                        ack_d   = ack_sel;
                        state_d = StAck;
                    end else begin
                        wcnt_d = wcnt_q + CNT_W'(1);
                    end
                end
                StAck: begin
                    ptr_d   = ptr_inc;
                    state_d = StIdle;
                    if (served_q == LastIdx) begin
                        served_d = '0;
                        blk_d    = blk_inc;
                        if ((blk_inc == total_blocks) && (total_blocks != '0)) begin
                            all_done_d = 1'b1;
                            state_d    = StDone;
                        end
                    end else begin
                        served_d = served_q + IDX_W'(1);
                    end
                end
                StDone: begin
                    all_done_d = 1'b1;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end

        busy_d = (state_d == StGrant) || (state_d == StWait) || (state_d == StAck);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StIdle;
            sel_q      <= '0;
            fl_start_q <= 1'b0;
            ack_q      <= '0;
            blk_q      <= '0;
            busy_q     <= 1'b0;
            all_done_q <= 1'b0;
            err_q      <= 1'b0;
            ptr_q      <= '0;
            served_q   <= '0;
            wcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            fl_start_q <= fl_start_d;
            ack_q      <= ack_d;
            blk_q      <= blk_d;
            busy_q     <= busy_d;
            all_done_q <= all_done_d;
            err_q      <= err_d;
            ptr_q      <= ptr_d;
            served_q   <= served_d;
            wcnt_q     <= wcnt_d;
        end
    end

    assign sel       = sel_q;
    assign fl_start  = fl_start_q;
    assign ack       = ack_q;
    assign blk_count = blk_q;
    assign busy      = busy_q;
    assign all_done  = all_done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_fl_sched.sv
// tb_fl_sched: directed bench for fl_sched. Expected grant order is pushed to
// a queue before stimulus; every ack pulse pops and checks sel/ack.
module tb_fl_sched;

    logic       clk;
    logic       rst;
    logic       enable;
    logic       restart;
    logic [6:0] total_blocks;
    logic [7:0] req;
    logic       fl_done;
    logic [2:0] sel;
    logic       fl_start;
    logic [7:0] ack;
    logic [6:0] blk_count;
    logic       busy;
    logic       all_done;
    logic       err;

    int total = 0;
    int bad   = 0;
    int n_start = 0;
    int snap;
    int exp_q[$];

    fl_sched #(
        .NUM(8), .IDX_W(3), .BLK_W(7), .TIMEOUT(255)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .restart(restart),
        .total_blocks(total_blocks), .req(req), .fl_done(fl_done),
        .sel(sel), .fl_start(fl_start), .ack(ack), .blk_count(blk_count),
        .busy(busy), .all_done(all_done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every ack pulse must match the oldest expected grant.
    always @(negedge clk) begin
        if (fl_start === 1'b1) n_start++;
        if (ack !== 8'h00) begin
            if (exp_q.size() == 0) begin
                check("ack_unexpected", {24'h0, ack}, 32'h0);
            end else begin
                int e;
                e = exp_q.pop_front();
                check("ack_sel", {29'h0, sel}, e);
                check("ack_onehot", {24'h0, ack}, 32'h1 << e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_start(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (fl_start === 1'b1) seen = 1'b1;
        end
        check({tag, "_start"}, {31'h0, seen}, 32'h1);
    endtask

    task automatic serve(input int exp_sel, input int lat, input bit drop);
        wait_start($sformatf("grant%0d", exp_sel));
        check("grant_sel", {29'h0, sel}, exp_sel);
        repeat (lat) @(negedge clk);
        fl_done = 1'b1;
        @(negedge clk);
        fl_done = 1'b0;
        if (drop) req[exp_sel] = 1'b0;
    endtask

    initial begin
        rst = 1'b0; enable = 1'b0; restart = 1'b0; total_blocks = 7'd0;
        req = 8'h00; fl_done = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_sel", {29'h0, sel}, 0);
        check("rst_fl_start", {31'h0, fl_start}, 0);
        check("rst_ack", {24'h0, ack}, 0);
        check("rst_blk", {25'h0, blk_count}, 0);
        check("rst_busy", {31'h0, busy}, 0);
        check("rst_all_done", {31'h0, all_done}, 0);
        check("rst_err", {31'h0, err}, 0);
        rst = 1'b1;

        // One full block, all units requesting, fl_done 2 cycles after start.
        total_blocks = 7'd1; enable = 1'b1; req = 8'hFF;
        for (int i = 0; i < 8; i++) exp_q.push_back(i);
        for (int i = 0; i < 8; i++) serve(i, 2, 1'b1);
        @(negedge clk);
        check("blk1_count", {25'h0, blk_count}, 1);
        check("blk1_all_done", {31'h0, all_done}, 1);
        check("blk1_busy", {31'h0, busy}, 0);
        check("blk1_starts", n_start, 8);
        check("done_sel_hold", {29'h0, sel}, 7);
        req = 8'hFF;
        repeat (5) @(negedge clk);
        check("done_no_grant", n_start, 8);
        check("done_sticky", {31'h0, all_done}, 1);

        // Restart, then rotating-pointer order: 2, then 7 before 1.
        req = 8'h04; total_blocks = 7'd0; restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        check("restart_all_done", {31'h0, all_done}, 0);
        check("restart_blk", {25'h0, blk_count}, 0);
        exp_q.push_back(2);
        serve(2, 1, 1'b1);
        req = 8'b1000_0010;
        exp_q.push_back(7); exp_q.push_back(1);
        serve(7, 1, 1'b1);
        serve(1, 1, 1'b1);

        // enable low blocks grants; dropping enable mid-transaction does not.
        enable = 1'b0; req = 8'h10;
        @(negedge clk);
        snap = n_start;
        repeat (6) @(negedge clk);
        check("en_low_no_start", n_start, snap);
        check("en_low_busy", {31'h0, busy}, 0);
        enable = 1'b1;
        exp_q.push_back(4);
        wait_start("en_grant");
        check("en_sel", {29'h0, sel}, 4);
        enable = 1'b0;
        repeat (3) @(negedge clk);
        fl_done = 1'b1;
        @(negedge clk);
        fl_done = 1'b0;
        check("en_drop_ack", {24'h0, ack}, 32'h10);
        req = 8'h00; enable = 1'b1;

        // Timeout: no fl_done, ACK with err TIMEOUT+1 cycles after GRANT.
        req = 8'h20;
        exp_q.push_back(5);
        wait_start("to_grant");
        check("to_sel", {29'h0, sel}, 5);
        repeat (255) @(negedge clk);
        check("to_early_ack", {24'h0, ack}, 0);
        check("to_early_err", {31'h0, err}, 0);
        @(negedge clk);
        check("to_ack", {24'h0, ack}, 32'h20);
        check("to_err", {31'h0, err}, 1);
        req = 8'h00;
        repeat (3) @(negedge clk);
        check("err_sticky", {31'h0, err}, 1);

        // restart coincident with fl_done in WAIT: no ack, counters/ptr cleared.
        req = 8'h01;
        wait_start("rs_grant");
        check("rs_sel", {29'h0, sel}, 0);
        @(negedge clk);
        fl_done = 1'b1; restart = 1'b1;
        @(negedge clk);
        fl_done = 1'b0; restart = 1'b0;
        check("rs_ack", {24'h0, ack}, 0);
        check("rs_busy", {31'h0, busy}, 0);
        check("rs_err", {31'h0, err}, 0);
        check("rs_blk", {25'h0, blk_count}, 0);
        req = 8'h81;
        exp_q.push_back(0); exp_q.push_back(7);
        serve(0, 1, 1'b1);
        serve(7, 1, 1'b1);

        // Unlimited blocks: three full blocks, all_done stays low.
        req = 8'hFF; restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < 8; i++) begin
                exp_q.push_back(i);
                serve(i, 1, 1'b0);
            end
        end
        req = 8'h08;
        @(negedge clk);
        check("unl_blk", {25'h0, blk_count}, 3);
        check("unl_all_done", {31'h0, all_done}, 0);

        // Synchronous reset mid-WAIT.
        wait_start("rw_grant");
        check("rw_sel", {29'h0, sel}, 3);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rw_sel0", {29'h0, sel}, 0);
        check("rw_fl_start", {31'h0, fl_start}, 0);
        check("rw_ack", {24'h0, ack}, 0);
        check("rw_blk", {25'h0, blk_count}, 0);
        check("rw_busy", {31'h0, busy}, 0);
        check("rw_all_done", {31'h0, all_done}, 0);
        check("rw_err", {31'h0, err}, 0);
        rst = 1'b1; req = 8'h00;
        repeat (4) @(negedge clk);
        check("sb_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
